// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state encoding and width helpers for the PLL lock sequencer
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  // ceil(log2(value)), never below 1 so a degenerate parameter still yields a real bus
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int cnt_width(input int rst_cycles, input int stable_cycles,
                                   input int timeout_cycles);
    int m;
    m = rst_cycles;
    if (stable_cycles > m) m = stable_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    return clog2_min1(m) + 1;
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(50, 5000, 50000);

endpackage

// File: rtl/pll_lock_sync.sv
// rtl/pll_lock_sync.sv - multi-flop synchroniser bringing pll_locked into the reference clock domain
module pll_lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - drives PLL reset, qualifies lock, releases system reset, retries on timeout
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 50,
  parameter int LOCK_STABLE_CYCLES  = 5000,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES         = 3,
  parameter int SYNC_STAGES         = 2,
  localparam int RW = clog2_min1(MAX_RETRIES + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pll_locked,
  input  logic          soft_reset_req,
  output logic          pll_rst,
  output logic          sys_reset_n,
  output logic          locked_ok,
  output logic          fail,
  output logic [RW-1:0] retry_count,
  output logic [15:0]   lock_loss_count
);

  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_MAX    = RW'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [15:0]      llc_q, llc_d;
  logic             pll_rst_q, run_q, fail_q;
  logic             locked_s;

  pll_lock_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clk),
    .rst_n(reset_n),
    .d_i  (pll_locked),
    .q_o  (locked_s)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    llc_d   = llc_q;

    if (soft_reset_req) begin
      state_d = ST_PLL_RST;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          // lock seen on the timeout cycle still counts as lock
          if (locked_s) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + RW'(1);
              state_d = ST_PLL_RST;
            end else begin
              state_d = ST_FAIL;
            end
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_d = ST_PLL_RST;
            retry_d = '0;
            if (llc_q != 16'hFFFF) llc_d = llc_q + 16'd1;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_PLL_RST;
        end
      endcase
    end
  end

  // the counter only runs in timed states and restarts on every state entry or soft restart
  always_comb begin
    cnt_d = '0;
    if (!soft_reset_req && state_d == state_q &&
        (state_q == ST_PLL_RST || state_q == ST_WAIT_LOCK || state_q == ST_STABLE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_PLL_RST;
      cnt_q     <= '0;
      retry_q   <= '0;
      llc_q     <= '0;
      pll_rst_q <= 1'b1;
      run_q     <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      llc_q     <= llc_d;
      pll_rst_q <= (state_d == ST_PLL_RST);
      run_q     <= (state_d == ST_RUN);
      fail_q    <= (state_d == ST_FAIL);
    end
  end

  assign pll_rst         = pll_rst_q;
  assign sys_reset_n     = run_q;
  assign locked_ok       = run_q;
  assign fail            = fail_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = llc_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - directed self-checking bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

  logic        clk;
  logic        reset_n;
  logic        pll_locked;
  logic        soft_reset_req;
  logic        pll_rst;
  logic        sys_reset_n;
  logic        locked_ok;
  logic        fail;
  logic [1:0]  retry_count;
  logic [15:0] lock_loss_count;

  int errors = 0;
  int checks = 0;
  int n;
  logic watch_sys = 1'b0;
  logic sys_seen  = 1'b0;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(20),
    .MAX_RETRIES        (2),
    .SYNC_STAGES        (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pll_locked     (pll_locked),
    .soft_reset_req (soft_reset_req),
    .pll_rst        (pll_rst),
    .sys_reset_n    (sys_reset_n),
    .locked_ok      (locked_ok),
    .fail           (fail),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (watch_sys && sys_reset_n) sys_seen = 1'b1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return pll_rst;
      1:       return sys_reset_n;
      default: return fail;
    endcase
  endfunction

  // counts falling edges, starting with the current one, while the selected output holds lvl
  task automatic count_while(input int sel, input logic lvl, output int cnt);
    cnt = 0;
    while (sig(sel) === lvl && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    pll_locked     = 1'b0;
    soft_reset_req = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_pll_rst", pll_rst, 1);
    check("rst_sys_reset_n", sys_reset_n, 0);
    check("rst_locked_ok", locked_ok, 0);
    check("rst_fail", fail, 0);
    check("rst_retry", retry_count, 0);
    check("rst_llc", lock_loss_count, 0);

    // power-up
    reset_n = 1'b1;
    count_while(0, 1'b1, n);
    check("pwr_pll_rst_len", n, 4);
    repeat (2) @(negedge clk);
    check("pwr_hold_before_lock", sys_reset_n, 0);
    pll_locked = 1'b1;
    count_while(1, 1'b0, n);
    check("pwr_release_edges", n - 1, 10);
    check("pwr_locked_ok", locked_ok, 1);
    check("pwr_retry", retry_count, 0);
    check("pwr_fail", fail, 0);

    // lock loss in RUN
    pll_locked = 1'b0;
    count_while(1, 1'b1, n);
    check("loss1_fall_edges", n - 1, 2);
    check("loss1_llc", lock_loss_count, 1);
    check("loss1_retry", retry_count, 0);
    check("loss1_locked_ok", locked_ok, 0);
    count_while(0, 1'b1, n);
    check("loss1_pll_rst_len", n, 4);

    // glitch at STABLE cnt=5: would have released on the same edge the loss is seen
    pll_locked = 1'b1;
    repeat (8) @(negedge clk);
    check("glitch_pre_sys", sys_reset_n, 0);
    pll_locked = 1'b0;
    repeat (2) @(negedge clk);
    check("glitch_no_release", sys_reset_n, 0);
    pll_locked = 1'b1;
    count_while(1, 1'b0, n);
    check("glitch_release_edges", n - 1, 10);
    check("glitch_llc", lock_loss_count, 1);

    // never lock: lock-loss pulse plus two retries, then FAIL
    pll_locked = 1'b0;
    count_while(1, 1'b1, n);
    check("loss2_fall_edges", n - 1, 2);
    check("loss2_llc", lock_loss_count, 2);
    sys_seen  = 1'b0;
    watch_sys = 1'b1;
    for (int p = 0; p < 3; p++) begin
      count_while(0, 1'b1, n);
      check($sformatf("never_pulse%0d_len", p), n, 4);
      check($sformatf("never_pulse%0d_retry", p), retry_count, p);
      if (p < 2) begin
        count_while(0, 1'b0, n);
        check($sformatf("never_wait%0d_len", p), n, 20);
      end else begin
        count_while(2, 1'b0, n);
        check("never_wait_to_fail", n, 20);
      end
    end
    check("fail_set", fail, 1);
    check("fail_pll_rst", pll_rst, 0);
    repeat (5) @(negedge clk);
    check("fail_hold", fail, 1);
    check("fail_hold_pll_rst", pll_rst, 0);
    check("fail_retry", retry_count, 2);
    watch_sys = 1'b0;
    check("never_sys_stayed_low", sys_seen, 0);

    // soft reset out of FAIL
    soft_reset_req = 1'b1;
    @(negedge clk);
    soft_reset_req = 1'b0;
    check("soft_fail_clear", fail, 0);
    check("soft_fail_pll_rst", pll_rst, 1);
    check("soft_fail_retry", retry_count, 0);
    check("soft_fail_llc", lock_loss_count, 2);
    count_while(0, 1'b1, n);
    check("soft_fail_pll_rst_len", n, 4);
    pll_locked = 1'b1;
    count_while(1, 1'b0, n);
    check("soft_fail_release_edges", n - 1, 10);

    // soft reset out of RUN with lock held: one WAIT_LOCK cycle then 8 stable cycles
    soft_reset_req = 1'b1;
    @(negedge clk);
    soft_reset_req = 1'b0;
    check("soft_run_sys", sys_reset_n, 0);
    check("soft_run_pll_rst", pll_rst, 1);
    check("soft_run_retry", retry_count, 0);
    check("soft_run_llc", lock_loss_count, 2);
    count_while(0, 1'b1, n);
    check("soft_run_pll_rst_len", n, 4);
    count_while(1, 1'b0, n);
    check("soft_run_release_cycles", n, 9);

    // third lock loss, then async reset mid-RUN
    pll_locked = 1'b0;
    count_while(1, 1'b1, n);
    check("loss3_fall_edges", n - 1, 2);
    check("loss3_llc", lock_loss_count, 3);
    count_while(0, 1'b1, n);
    check("loss3_pll_rst_len", n, 4);
    pll_locked = 1'b1;
    count_while(1, 1'b0, n);
    check("loss3_release_edges", n - 1, 10);
    check("pre_areset_llc", lock_loss_count, 3);

    #2 reset_n = 1'b0;
    #1;
    check("areset_pll_rst", pll_rst, 1);
    check("areset_sys", sys_reset_n, 0);
    check("areset_locked_ok", locked_ok, 0);
    check("areset_llc", lock_loss_count, 0);
    check("areset_retry", retry_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
